// File: rtl/glitch_sweep.sv
// Delay-sweep sequencer: for each delay in [start..end] by step, requests one target reset,
// waits the delay after reset completes, then fires one glitch pulse of programmed width.
module glitch_sweep #(
    parameter int unsigned DELAY_W = 16,
    parameter int unsigned WIDTH_W = 8,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clk_in,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [DELAY_W-1:0] delay_start,
    input  logic [DELAY_W-1:0] delay_end,
    input  logic [DELAY_W-1:0] delay_step,
    input  logic [WIDTH_W-1:0] pulse_width,
    input  logic               reset_ready,
    output logic               reset_en,
    output logic               glitch_o,
    output logic               busy,
    output logic               done,
    output logic [DELAY_W-1:0] cur_delay,
    output logic [CNT_W-1:0]   attempts
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_WAIT_RST,
        ST_DELAY,
        ST_PULSE,
        ST_NEXT
    } state_t;

    state_t               state_q, state_d;
    logic [DELAY_W-1:0]   end_q, end_d;
    logic [DELAY_W-1:0]   step_q, step_d;
    logic [WIDTH_W-1:0]   width_q, width_d;
    logic [DELAY_W-1:0]   dcnt_q, dcnt_d;
    logic [WIDTH_W-1:0]   pcnt_q, pcnt_d;
    logic [DELAY_W-1:0]   cur_delay_d;
    logic [CNT_W-1:0]     attempts_d;
    logic                 reset_en_d, glitch_o_d, busy_d, done_d;
    logic [DELAY_W:0]     next_sum;

    // State and registered outputs
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            end_q     <= '0;
            step_q    <= '0;
            width_q   <= '0;
            dcnt_q    <= '0;
            pcnt_q    <= '0;
            cur_delay <= '0;
            attempts  <= '0;
            reset_en  <= 1'b0;
            glitch_o  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            end_q     <= end_d;
            step_q    <= step_d;
            width_q   <= width_d;
            dcnt_q    <= dcnt_d;
            pcnt_q    <= pcnt_d;
            cur_delay <= cur_delay_d;
            attempts  <= attempts_d;
            reset_en  <= reset_en_d;
            glitch_o  <= glitch_o_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

    assign next_sum = {1'b0, cur_delay} + {1'b0, step_q};

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        end_d       = end_q;
        step_d      = step_q;
        width_d     = width_q;
        dcnt_d      = dcnt_q;
        pcnt_d      = pcnt_q;
        cur_delay_d = cur_delay;
        attempts_d  = attempts;
        reset_en_d  = 1'b0;
        glitch_o_d  = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    attempts_d = '0;
                    if (delay_start > delay_end) begin
                        done_d = 1'b1;
                    end else begin
                        end_d       = delay_end;
                        step_d      = delay_step;
                        width_d     = (pulse_width == '0) ? WIDTH_W'(1) : pulse_width;
                        cur_delay_d = delay_start;
                        state_d     = ST_ARM;
                    end
                end
            end
            ST_ARM: begin
                if (reset_ready) begin
                    reset_en_d = 1'b1;
                    state_d    = ST_WAIT_RST;
                end
            end
            ST_WAIT_RST: begin
                // reset_en is still high in the first cycle here, while ready is stale
                if (!reset_en && reset_ready) begin
                    dcnt_d  = cur_delay;
                    state_d = ST_DELAY;
                end
            end
            ST_DELAY: begin
                if (dcnt_q == '0) begin
                    glitch_o_d = 1'b1;
                    pcnt_d     = width_q - WIDTH_W'(1);
                    attempts_d = (attempts == '1) ? attempts : attempts + CNT_W'(1);
                    state_d    = ST_PULSE;
                end else begin
                    dcnt_d = dcnt_q - DELAY_W'(1);
                end
            end
            ST_PULSE: begin
                if (pcnt_q == '0) begin
                    state_d = ST_NEXT;
                end else begin
                    glitch_o_d = 1'b1;
                    pcnt_d     = pcnt_q - WIDTH_W'(1);
                end
            end
            ST_NEXT: begin
                if (next_sum[DELAY_W] || (next_sum[DELAY_W-1:0] > end_q) || (step_q == '0)) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cur_delay_d = next_sum[DELAY_W-1:0];
                    state_d     = ST_ARM;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // abort overrides everything, progress counters are frozen
        if (abort) begin
            state_d     = ST_IDLE;
            reset_en_d  = 1'b0;
            glitch_o_d  = 1'b0;
            done_d      = 1'b0;
            cur_delay_d = cur_delay;
            attempts_d  = attempts;
        end

        busy_d = (state_d != ST_IDLE);
    end

endmodule

// File: doc/glitch_sweep.md
# glitch_sweep

Upstream sequencer for the glitch reset stage. On a start command it walks a programmable range of glitch delays; for each delay it requests one target-reset cycle from `glitch_reset` via `reset_en`/`reset_ready`, waits the programmed delay after reset completes, then fires one `glitch_o` pulse of programmed width. It reports progress (`cur_delay`, `attempts`) and signals completion, so a host interface can run an unattended delay sweep.

## Interface
- `DELAY_W`, 16: width of all delay fields and counters.
- `WIDTH_W`, 8: width of the pulse-width field.
- `CNT_W`, 16: width of the attempt counter.

- `clk_in`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  start-sweep request; sampled only in IDLE.
- `abort`  in  1  cancel the sweep; wins over every other event.
- `delay_start`  in  DELAY_W  first delay, in cycles.
- `delay_end`  in  DELAY_W  last allowed delay, inclusive.
- `delay_step`  in  DELAY_W  delay increment per attempt.
- `pulse_width`  in  WIDTH_W  glitch width in cycles; 0 is treated as 1.
- `reset_ready`  in  1  from `glitch_reset` `ready`.
- `reset_en`  out  1  to `glitch_reset` `en`; one-cycle request.
- `glitch_o`  out  1  glitch pulse; registered.
- `busy`  out  1  sweep in progress.
- `done`  out  1  one-cycle pulse at normal sweep completion.
- `cur_delay`  out  DELAY_W  delay of the current or last attempt.
- `attempts`  out  CNT_W  number of glitch pulses issued in this sweep.

## Operation
- States: IDLE, ARM, WAIT_RST, DELAY, PULSE, NEXT.
- **IDLE, `start`=1:**
  - If `delay_start > delay_end`: emit `done` for one cycle, set `attempts`=0, and stay in IDLE.
  - Otherwise: latch `delay_end`, `delay_step` and `max(pulse_width,1)`; set `cur_delay`=`delay_start` and `attempts`=0; go to ARM.
  - Config inputs are ignored after the latch.
- **ARM:** wait for `reset_ready`=1. In the cycle it is sampled high, drive `reset_en`=1 for exactly that one cycle, then go to WAIT_RST.
- **WAIT_RST:** ignore `reset_ready` for the first cycle, because the downstream stage drops `ready` while busy. When `reset_ready` is next sampled 1, load the delay counter with `cur_delay` and go to DELAY.
- **DELAY:** count down. When the count reaches 0, go to PULSE. Delay 0 means zero DELAY cycles.
- **PULSE:** `glitch_o`=1 for exactly the latched width. `attempts` increments, saturating at all-ones, on the first PULSE cycle. Then go to NEXT.
- **NEXT:** compute `cur_delay + delay_step` at DELAY_W+1 bits.
  - If there is a carry out, or the sum exceeds `delay_end`, or `delay_step`=0: assert `done`, drop `busy`, go to IDLE, and keep `cur_delay` at the last used value.
  - Otherwise: update `cur_delay` and go to ARM.
- **abort, any state:** the next edge forces IDLE and clears `glitch_o`, `reset_en` and `busy`. No `done` pulse. `cur_delay` and `attempts` are held.
- `start` while busy is ignored.
- `busy` is high in every state except IDLE.

## Timing
- **Reset values:** `reset_en`=0, `glitch_o`=0, `busy`=0, `done`=0, `cur_delay`=0, `attempts`=0, state IDLE. Reset is asynchronous assert, with release synchronised to `clk_in` externally.
- All outputs are registered; there is no combinational path from inputs to outputs.
- **Start:** `start` sampled at edge 0 gives ARM and `busy`=1 after edge 0. `reset_en` rises at edge 1 if `reset_ready` was already high.
- **Glitch placement:** let edge R be the edge at which WAIT_RST samples `reset_ready`=1. Then `glitch_o` rises at edge R+D+1 and falls at edge R+D+1+W. D is the current delay; W is the effective width.
- **NEXT:** takes exactly 1 cycle.
- **Attempt count:** a sweep issues floor((end−start)/step)+1 pulses when step>0, and 1 pulse when step=0.
- **Edge conditions:**
  - `reset_ready` held low forever in ARM: wait indefinitely, with `abort` as the only exit.
  - `abort` and a PULSE end on the same edge: `abort` wins.
  - Reset mid-pulse: `glitch_o` drops asynchronously.

## Test plan
- **Basic sweep:**
  - Stimulus: start=10, end=30, step=10, width=4, with a `glitch_reset` model (11-cycle reset).
  - Required response: three pulses at D=10/20/30, each 4 cycles wide with rise at R+D+1; `attempts`=3; one `done`; `cur_delay`=30.
- **Zero delay/width:**
  - Stimulus: start=end=0, width=0.
  - Required response: one 1-cycle pulse rising at R+1, then `done`.
- **Empty range:**
  - Stimulus: start=5, end=4.
  - Required response: `done` one cycle after `start`; no `reset_en`; `busy` never high.
- **Overflow:**
  - Stimulus: DELAY_W=16, start=0xFFF0, end=0xFFFF, step=0x20.
  - Required response: exactly one pulse; `done`; `cur_delay`=0xFFF0.
- **Abort mid-pulse:**
  - Stimulus: assert `abort` during the 2nd PULSE cycle of a width=8 pulse.
  - Required response: `glitch_o` low after the next edge; `busy`=0; no `done`; `attempts`=1.
- **Handshake:**
  - Stimulus: hold `reset_ready`=0 for 50 cycles in ARM.
  - Required response: `reset_en` stays 0; when `reset_ready` rises, `reset_en` is exactly one cycle high; asynchronous `rst_n` mid-DELAY returns all outputs to their reset values immediately.
